// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: ring base address and FSM state encoding.
package uart_rx_pkg;

  localparam int WORD_LEN = 32;
  localparam logic [WORD_LEN-1:0] UART_RX_BASE = 32'h0000_2000;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_WRITE  = 3'd5,
    RX_BREAK  = 3'd6
  } rx_state_e;

  // Ring slots are word-spaced.
  function automatic logic [WORD_LEN-1:0] slot_addr(input logic [WORD_LEN-1:0] base,
                                                    input logic [WORD_LEN-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to 1 (idle-high lines).
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) that writes each good byte into a memory ring via a one-cycle intr steal.
// Define UART_RX_PARITY_EN for an even-parity bit after bit 7 and a parity_err output.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int                  CLKS_PER_BIT = 16,
  parameter logic [WORD_LEN-1:0] RX_BASE      = UART_RX_BASE,
  parameter int                  RX_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        uart_in,
  output logic                        intr,
  output logic [WORD_LEN-1:0]         addr_d_uart,
  output logic [WORD_LEN-1:0]         wdata_uart,
  output logic [$clog2(RX_DEPTH)-1:0] wr_ptr,
  output logic                        busy,
  output logic                        frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                        parity_err
`endif
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_e AFTER_DATA = RX_STOP;
`endif

  logic rx_s;

  sync2 u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (uart_in),
    .q    (rx_s)
  );

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            shift_q, shift_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  intr_q, intr_d;
  logic [WORD_LEN-1:0]   addr_q, addr_d;
  logic [WORD_LEN-1:0]   wdata_q, wdata_d;
  logic                  ferr_q, ferr_d;
  logic                  discard;
  logic                  bit_done;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic pbad_q, pbad_d;
  assign discard = pbad_q;
`else
  assign discard = 1'b0;
`endif

  assign bit_done = (cnt_q == BIT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    intr_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = 1'b0;
    pbad_d   = pbad_q;
`endif
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        pbad_d = 1'b0;
`endif
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_done) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = RX_STOP;
          if (^{shift_q, rx_s}) begin
            perr_d = 1'b1;
            pbad_d = 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end else if (discard) begin
            state_d = RX_IDLE;
          end else begin
            // Outputs are registered, so they are loaded on entry to WRITE.
            state_d = RX_WRITE;
            intr_d  = 1'b1;
            addr_d  = slot_addr(RX_BASE, WORD_LEN'(wr_ptr_q));
            wdata_d = {{(WORD_LEN - 8){1'b0}}, shift_q};
          end
        end
      end
      RX_WRITE: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        state_d  = RX_IDLE;
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      intr_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
      pbad_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      intr_q   <= intr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
      pbad_q   <= pbad_d;
`endif
    end
  end

  assign intr        = intr_q;
  assign addr_d_uart = addr_q;
  assign wdata_uart  = wdata_q;
  assign wr_ptr      = wr_ptr_q;
  assign busy        = (state_q != RX_IDLE);
  assign frame_err   = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (ring depth 8 and 4) share one serial line; table vectors,
// hand sequences for glitch/reset/parity, and random frames checked against a frame-level model.
module tb_uart_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_in;
  logic        intr  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        busy  [2];
  logic        ferr  [2];
  logic [2:0]  ptr8;
  logic [1:0]  ptr4;
`ifdef UART_RX_PARITY_EN
  logic        perr  [2];
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .RX_DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .uart_in(uart_in), .intr(intr[0]),
    .addr_d_uart(addr[0]), .wdata_uart(wdata[0]), .wr_ptr(ptr8),
    .busy(busy[0]), .frame_err(ferr[0])
`ifdef UART_RX_PARITY_EN
    , .parity_err(perr[0])
`endif
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .RX_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .uart_in(uart_in), .intr(intr[1]),
    .addr_d_uart(addr[1]), .wdata_uart(wdata[1]), .wr_ptr(ptr4),
    .busy(busy[1]), .frame_err(ferr[1])
`ifdef UART_RX_PARITY_EN
    , .parity_err(perr[1])
`endif
  );

  // Pulse monitors, sampled on the falling edge.
  int          wcnt [2] = '{0, 0};
  int          fcnt [2] = '{0, 0};
  int          pcnt [2] = '{0, 0};
  int          dbl = 0;
  logic        prev_intr [2] = '{1'b0, 1'b0};
  logic [31:0] cap_addr [2];
  logic [31:0] cap_data [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (intr[d]) begin
        wcnt[d]     <= wcnt[d] + 1;
        cap_addr[d] <= addr[d];
        cap_data[d] <= wdata[d];
        if (prev_intr[d]) dbl <= dbl + 1;
      end
      if (ferr[d]) fcnt[d] <= fcnt[d] + 1;
`ifdef UART_RX_PARITY_EN
      if (perr[d]) pcnt[d] <= pcnt[d] + 1;
`endif
      prev_intr[d] <= intr[d];
    end
  end

  int checks = 0;
  int errors = 0;
  // Frame-level model: good writes since reset, and running pulse totals.
  int good = 0;
  int exp_w = 0;
  int exp_f = 0;
  int exp_p = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         tail;
    int         gap;
    logic       exp_write;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  function automatic int dep(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic int ptr_of(input int d);
    return (d == 0) ? int'(ptr8) : int'(ptr4);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h", name, d, act, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    uart_in = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic badp,
                            input int tail, input int gap);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^b) ^ badp);
`endif
    bit_out(stop);
    if (tail > 0) begin
      uart_in = 1'b0;
      tick(tail);
    end
    uart_in = 1'b1;
    tick(gap);
  endtask

  task automatic check_all(input logic ew, input logic [7:0] b);
    logic [31:0] ea;
    for (int d = 0; d < 2; d++) begin
      chk(d, "write_count", 32'(wcnt[d]), 32'(exp_w));
      chk(d, "frame_err_count", 32'(fcnt[d]), 32'(exp_f));
`ifdef UART_RX_PARITY_EN
      chk(d, "parity_err_count", 32'(pcnt[d]), 32'(exp_p));
`endif
      chk(d, "wr_ptr", 32'(ptr_of(d)), 32'(good % dep(d)));
      chk(d, "busy_idle", 32'(busy[d]), 32'd0);
      if (ew) begin
        ea = 32'h2000 + 32'(4 * ((good - 1) % dep(d)));
        chk(d, "write_addr", cap_addr[d], ea);
        chk(d, "write_data", cap_data[d], {24'd0, b});
        chk(d, "addr_hold", addr[d], ea);
        chk(d, "data_hold", wdata[d], {24'd0, b});
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic stop, input logic badp,
                           input int tail, input int gap,
                           input logic ew, input logic ef, input logic ep);
    send_frame(b, stop, badp, tail, gap);
    if (ew) begin
      good++;
      exp_w++;
    end
    if (ef) exp_f++;
    if (ep) exp_p++;
    check_all(ew, b);
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_intr", 32'(intr[d]), 32'd0);
      chk(d, "rst_addr", addr[d], 32'd0);
      chk(d, "rst_wdata", wdata[d], 32'd0);
      chk(d, "rst_wr_ptr", 32'(ptr_of(d)), 32'd0);
      chk(d, "rst_busy", 32'(busy[d]), 32'd0);
      chk(d, "rst_frame_err", 32'(ferr[d]), 32'd0);
`ifdef UART_RX_PARITY_EN
      chk(d, "rst_parity_err", 32'(perr[d]), 32'd0);
`endif
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       badp;
    int         tail;
    int         gap;

    vecs[0] = '{8'h41, 1'b1,  0, 20, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 1'b1,  0,  0, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b1,  0, 20, 1'b1, 1'b0};
    vecs[3] = '{8'h33, 1'b0, 40, 20, 1'b0, 1'b1};
    vecs[4] = '{8'h7E, 1'b1,  0, 20, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1,  0,  5, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b1,  0,  5, 1'b1, 1'b0};

    rst_n   = 1'b0;
    uart_in = 1'b1;
    tick(2);
    check_reset_state();
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].data, vecs[i].stop, 1'b0, vecs[i].tail, vecs[i].gap,
                vecs[i].exp_write, vecs[i].exp_ferr, 1'b0);

    // Short low pulse: receiver wakes, rejects at mid start bit, writes nothing.
    uart_in = 1'b0;
    tick(3);
    chk(0, "glitch_busy_high", 32'(busy[0]), 32'd1);
    uart_in = 1'b1;
    tick(10);
    check_all(1'b0, 8'h00);

`ifdef UART_RX_PARITY_EN
    run_frame(8'h41, 1'b1, 1'b1, 0, 20, 1'b0, 1'b0, 1'b1);
    run_frame(8'h96, 1'b0, 1'b1, 10, 20, 1'b0, 1'b1, 1'b1);
    run_frame(8'h96, 1'b1, 1'b0, 0, 20, 1'b1, 1'b0, 1'b0);
`endif

    // Reset during data bit 4 of 0x41: async clear, then a clean frame lands in slot 0.
    b = 8'h41;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(b[i]);
    uart_in = b[4];
    tick(CPB / 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    good = 0;
    uart_in = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    run_frame(8'h41, 1'b1, 1'b0, 0, 20, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      badp = ($urandom_range(0, 4) == 0);
`else
      badp = 1'b0;
`endif
      tail = stop ? 0 : $urandom_range(0, 30);
      gap  = stop ? $urandom_range(0, 6) : 8;
      run_frame(b, stop, badp, tail, gap, stop && !badp, !stop, badp);
    end

    chk(0, "intr_back_to_back_cycles", 32'(dbl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
